psum_deskew: RTL and testbench

PSUM_DESKEW -- requirements
Module: psum_deskew

---
 rtl/psum_deskew_pkg.sv | 19 +
 rtl/psum_fifo.sv | 52 +++++
 rtl/psum_deskew.sv | 104 ++++++++++
 tb/tb_psum_deskew.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_deskew_pkg.sv
// Shared accelerator parameters and helpers for the PE array and its bottom-row deskew/output buffer.
package psum_deskew_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned ARRAY_M      = 16;
  localparam int unsigned ARRAY_N      = 16;
  localparam int unsigned LOG2_ARRAY_M = 4;

  // Accumulated partial-sum width: full product plus growth over array_m rows.
  function automatic int unsigned psum_width(input int unsigned dw, input int unsigned lg);
    return 2 * dw + lg;
  endfunction

  // LSB position of a lane inside a packed lane vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Small output buffer: synchronous push/pop, occupancy counter one bit wider than the pointers.
module psum_fifo #(
  parameter int unsigned width = 20,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CNT_W = $clog2(depth) + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push while full only lands when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full     = (count == CNT_W'(depth));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: contents are only observable behind a non-zero count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_deskew.sv
// Realigns the skewed bottom-row partial sums of the PE array into whole vectors and buffers them.
module psum_deskew
  import psum_deskew_pkg::*;
#(
  parameter int unsigned data_width   = DATA_WIDTH,
  parameter int unsigned array_m      = ARRAY_M,
  parameter int unsigned array_n      = ARRAY_N,
  parameter int unsigned log2_array_m = LOG2_ARRAY_M,
  parameter int unsigned fifo_depth   = 4
) (
  input  logic                                                     clk,
  input  logic                                                     rst_n,
  input  logic [array_n*psum_width(data_width, log2_array_m)-1:0] psum_in,
  input  logic                                                     in_valid,
  output logic [array_n*psum_width(data_width, log2_array_m)-1:0] out_data,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic                                                     out_last,
  output logic                                                     overflow
);

  localparam int unsigned PSUM_W = psum_width(data_width, log2_array_m);
  localparam int unsigned VEC_W  = array_n * PSUM_W;
  localparam int unsigned ROW_W  = (array_m > 1) ? $clog2(array_m) : 1;

  logic [VEC_W-1:0] aligned;
  logic             aligned_valid;
  logic [VEC_W-1:0] fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;
  logic [ROW_W-1:0] row_cnt;

  // Column j arrives j cycles late, so it waits array_n-1-j cycles to line up with the last column.
  for (genvar j = 0; j < int'(array_n); j++) begin : g_lane
    localparam int unsigned DLY = array_n - 1 - j;
    if (DLY == 0) begin : g_pass
      assign aligned[lane_lsb(j, PSUM_W) +: PSUM_W] = psum_in[lane_lsb(j, PSUM_W) +: PSUM_W];
    end else begin : g_dly
      logic [PSUM_W-1:0] line [DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < int'(DLY); k++) line[k] <= '0;
        end else begin
          line[0] <= psum_in[lane_lsb(j, PSUM_W) +: PSUM_W];
          for (int k = 1; k < int'(DLY); k++) line[k] <= line[k-1];
        end
      end
      assign aligned[lane_lsb(j, PSUM_W) +: PSUM_W] = line[DLY-1];
    end
  end

  // Row tag follows column 0 down the same number of stages.
  if (array_n > 1) begin : g_vld
    logic [array_n-2:0] vld_sr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_sr <= '0;
      end else begin
        vld_sr[0] <= in_valid;
        for (int k = 1; k < int'(array_n) - 1; k++) vld_sr[k] <= vld_sr[k-1];
      end
    end
    assign aligned_valid = vld_sr[array_n-2];
  end else begin : g_vld_pass
    assign aligned_valid = in_valid;
  end

  assign fifo_pop = out_valid && out_ready;
  assign drop     = aligned_valid && fifo_full && !fifo_pop;

  psum_fifo #(
    .width (VEC_W),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (aligned_valid),
    .push_data (aligned),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_data : '0;
  assign out_last  = out_valid && (row_cnt == ROW_W'(array_m - 1));

  // Row position within the tile advances only on vectors actually delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_pop) begin
        row_cnt <= (row_cnt == ROW_W'(array_m - 1)) ? '0 : row_cnt + ROW_W'(1);
      end
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_deskew.sv
// Randomised scoreboard bench for psum_deskew: whole rows are scheduled, skewed by the driver, and expected back intact.
module tb_psum_deskew;

  localparam int N     = 16;
  localparam int M     = 16;
  localparam int W     = 20;
  localparam int DEPTH = 4;
  localparam int VW    = N * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [VW-1:0] psum_in = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          overflow;

  always #5 clk = ~clk;

  psum_deskew #(
    .data_width   (8),
    .array_m      (M),
    .array_n      (N),
    .log2_array_m (4),
    .fifo_depth   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_in   (psum_in),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            base;
  logic [VW-1:0] rows [int];   // whole row vector keyed by its issue cycle
  logic [VW-1:0] exp_q [$];
  int            occ = 0;
  bit            m_ovf = 1'b0;
  int            rst_cyc = 0;
  int            pops = 0;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  function automatic void sched(input int t, input logic [VW-1:0] v);
    rows[t] = v;
  endfunction

  function automatic logic [VW-1:0] rand_row();
    logic [VW-1:0] v;
    for (int j = 0; j < N; j++) v[j*W +: W] = W'($urandom);
    return v;
  endfunction

  // Advance one cycle and drive the skewed array output: column j carries the row issued j cycles ago.
  task automatic tick();
    logic [VW-1:0] v;
    @(posedge clk);
    #1;
    cyc++;
    in_valid = rows.exists(cyc) ? 1'b1 : 1'b0;
    for (int j = 0; j < N; j++) begin
      if (rows.exists(cyc - j)) begin
        v = rows[cyc - j];
        psum_in[j*W +: W] = v[j*W +: W];
      end else begin
        psum_in[j*W +: W] = W'($urandom);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, '0);
    run(3);
    #3 rst_n = 1'b1;
  endtask

  // Reference: a row issued at t is offered to a depth-4 buffer at the end of cycle t+N-1.
  always @(posedge clk or negedge rst_n) begin : model
    bit popm;
    int t;
    if (!rst_n) begin
      exp_q.delete();
      occ     = 0;
      m_ovf   = 1'b0;
      rst_cyc = cyc;
    end else begin
      popm = (occ > 0) && out_ready;
      t    = cyc - (N - 1);
      if (t > rst_cyc && rows.exists(t)) begin
        if (occ < DEPTH || popm) begin
          exp_q.push_back(rows[t]);
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (popm) occ--;
    end
  end

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      pops = 0;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      check("reset_out_data", out_data, '0);
    end else begin
      check("out_valid", out_valid, (occ > 0));
      check("overflow", overflow, m_ovf);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_vector at cycle %0d: got %0h, required none", cyc, out_data);
        end else begin
          check("out_data", out_data, exp_q[0]);
          check("out_last", out_last, ((pops % M) == M - 1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got timeout, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] r0;

    run(3);
    #3 rst_n = 1'b1;

    // Single row: in_valid at cycle 10, out_valid visible exactly at 26 and gone at 27.
    base = cyc;
    for (int j = 0; j < N; j++) v[j*W +: W] = W'(j + 1);
    sched(base + 10, v);
    out_ready = 1'b1;
    while (cyc < base + 25) tick();
    @(negedge clk);
    check("t1_before", out_valid, 0);
    tick();
    @(negedge clk);
    check("t1_rise", out_valid, 1);
    check("t1_data", out_data, v);
    tick();
    @(negedge clk);
    check("t1_fall", out_valid, 0);
    run(3);

    // Streaming tile: 16 back-to-back rows, lane j of row r = 100*r+j.
    pulse_reset();
    base = cyc;
    out_ready = 1'b1;
    for (int r = 0; r < M; r++) begin
      for (int j = 0; j < N; j++) v[j*W +: W] = W'(100 * r + j);
      sched(base + 2 + r, v);
    end
    run(45);
    check("t2_pops", pops, M);

    // Backpressure: four rows fit, head row held while out_ready is low.
    pulse_reset();
    base = cyc;
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      r0 = rand_row();
      sched(base + 2 + r, r0);
    end
    r0 = rows[base + 2];
    run(26);
    @(negedge clk);
    check("t3_hold_valid", out_valid, 1);
    check("t3_hold_data", out_data, r0);
    check("t3_no_overflow", overflow, 0);
    out_ready = 1'b1;
    run(10);
    check("t3_pops", pops, 4);

    // Overflow: fifth row with no pop is lost, first four survive.
    pulse_reset();
    base = cyc;
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) sched(base + 2 + r, rand_row());
    run(26);
    @(negedge clk);
    check("t4_overflow", overflow, 1);
    out_ready = 1'b1;
    run(10);
    check("t4_pops", pops, 4);
    check("t4_sticky", overflow, 1);

    // Full buffer with a pop in the very cycle the fifth row arrives: nothing dropped.
    pulse_reset();
    base = cyc;
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) sched(base + 2 + r, rand_row());
    while (cyc < base + 6 + N - 1) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    run(3);
    @(negedge clk);
    check("t5_no_overflow", overflow, 0);
    check("t5_still_valid", out_valid, 1);
    out_ready = 1'b1;
    run(10);
    check("t5_pops", pops, 5);

    // Signed extremes on every lane.
    pulse_reset();
    base = cyc;
    out_ready = 1'b1;
    for (int j = 0; j < N; j++) v[j*W +: W] = (j % 2 == 0) ? 20'h80000 : 20'h7FFFF;
    sched(base + 2, v);
    for (int j = 0; j < N; j++) v[j*W +: W] = (j % 2 == 0) ? 20'h7FFFF : 20'h80000;
    sched(base + 3, v);
    v = '1;
    sched(base + 4, v);
    run(30);
    check("t6_pops", pops, 3);

    // Random traffic with random gaps and random consumer stalls.
    pulse_reset();
    for (int i = 0; i < 250; i++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) sched(cyc + 1, rand_row());
    end
    out_ready = 1'b1;
    run(30);

    // Reset mid-tile after seven pops; the following tile must still mark its 16th row last.
    pulse_reset();
    base = cyc;
    out_ready = 1'b1;
    for (int r = 0; r < M; r++) sched(base + 2 + r, rand_row());
    for (int i = 0; i < 60 && pops < 7; i++) tick();
    check("t8_seven_pops", pops, 7);
    pulse_reset();
    base = cyc;
    for (int r = 0; r < M; r++) sched(base + 2 + r, rand_row());
    run(45);
    check("t8_pops", pops, M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
